// File: rtl/mul_hilo_ctrl_if.sv
// mul_hilo_ctrl_if: request/result bundle between the pipeline and the HI/LO multiply sequencer.
interface mul_hilo_ctrl_if #(parameter int WIDTH = 32);
  logic             start, is_signed, rd_hi, rd_lo;
  logic [WIDTH-1:0] a, b;
  logic             busy, stall, done, rd_valid;
  logic [WIDTH-1:0] hi, lo, rd_data;
  modport master (output start, is_signed, a, b, rd_hi, rd_lo,
                  input  busy, stall, done, hi, lo, rd_data, rd_valid);
  modport slave  (input  start, is_signed, a, b, rd_hi, rd_lo,
                  output busy, stall, done, hi, lo, rd_data, rd_valid);
endinterface

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: radix-2 shift-add multiply sequencer owning HI/LO, stalling the pipeline while busy.
// Magnitudes are multiplied unsigned and the sign is applied once in FIX, so the most negative operand is exact.
module mul_hilo_ctrl #(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           reset_n,
  mul_hilo_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_hi, r_lo;
  logic [CW-1:0]      r_count;
  logic               r_neg, r_done;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_busy;
  assign w_abs_a = (bus.is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b = (bus.is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_busy  = r_state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
          r_mplier <= w_abs_b;
          r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          r_acc    <= '0;
          r_count  <= '0;
          r_state  <= RUN;
        end
        RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == CW'(WIDTH-1)) r_state <= FIX;
        end
        FIX: begin
          {r_hi, r_lo} <= r_neg ? -r_acc : r_acc;
          r_done       <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.stall    = w_busy & (bus.start | bus.rd_hi | bus.rd_lo);
  assign bus.rd_valid = ~w_busy & (bus.rd_hi | bus.rd_lo);
  assign bus.rd_data  = bus.rd_hi ? r_hi : r_lo;
endmodule
